bft_stream_tx: RTL and testbench

//  Host-side transmitter that injects one 32-bit valid/ready stream into the BFT as 49-bit packets addressed to one
//  (leaf, port) input of a leaf_interface; the sending end of the leaf input-port protocol.

---
 rtl/bft_pkg.sv | 38 +++
 rtl/bft_stream_tx_if.sv | 22 ++
 rtl/bft_credit_counter.sv | 41 ++++
 rtl/bft_stream_tx.sv | 91 +++++++++
 tb/tb_bft_stream_tx.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/bft_pkg.sv
// Shared BFT definitions: packet field positions, credit sizing and transmitter FSM states.
package bft_pkg;

  localparam int unsigned PACKET_BITS   = 49;
  localparam int unsigned PAYLOAD_BITS  = 32;
  localparam int unsigned NUM_LEAF_BITS = 4;
  localparam int unsigned NUM_PORT_BITS = 4;
  localparam int unsigned NUM_ADDR_BITS = 7;

  localparam int unsigned VALID_BIT = 48;
  localparam int unsigned LEAF_MSB  = 47;
  localparam int unsigned LEAF_LSB  = 44;
  localparam int unsigned PORT_MSB  = 43;
  localparam int unsigned PORT_LSB  = 40;
  localparam int unsigned ADDR_MSB  = 39;
  localparam int unsigned ADDR_LSB  = 33;
  localparam int unsigned CTRL_BIT  = 32;

  // Credits span 0..2**NUM_ADDR_BITS inclusive, hence one extra bit.
  localparam int unsigned CREDIT_BITS = NUM_ADDR_BITS + 1;
  localparam int unsigned CREDIT_MAX  = 2 ** NUM_ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic                     valid;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] port;
    logic [NUM_ADDR_BITS-1:0] addr;
    logic                     ctrl;
    logic [PAYLOAD_BITS-1:0]  payload;
  } bft_pkt_t;

endpackage

// File: rtl/bft_stream_tx_if.sv
// Host stream plus BFT port bundle of one stream transmitter.
interface bft_stream_tx_if;
  import bft_pkg::*;

  logic [PAYLOAD_BITS-1:0] s_tdata;
  logic                    s_tvalid;
  logic                    s_tready;
  logic [PACKET_BITS-1:0]  din_bft;
  logic [PACKET_BITS-1:0]  dout_bft;
  logic                    resend;
  logic [CREDIT_BITS-1:0]  credits;

  modport master (
    output s_tdata, s_tvalid, din_bft, resend,
    input  s_tready, dout_bft, credits
  );

  modport slave (
    input  s_tdata, s_tvalid, din_bft, resend,
    output s_tready, dout_bft, credits
  );
endinterface

// File: rtl/bft_credit_counter.sv
// Saturating credit counter: one optional decrement and one optional bulk return per cycle.
module bft_credit_counter
  import bft_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_dec,
  input  logic                   i_inc_en,
  input  logic [CREDIT_BITS-1:0] i_inc,
  output logic [CREDIT_BITS-1:0] o_credits
);

  localparam int unsigned SUM_BITS = CREDIT_BITS + 2;

  logic [CREDIT_BITS-1:0] r_credits;
  logic [CREDIT_BITS-1:0] w_credits_nxt;
  logic [SUM_BITS-1:0]    w_sum;

  // Decrement only happens with credits!=0, so the sum cannot go negative.
  always_comb begin
    w_sum = SUM_BITS'(r_credits) - SUM_BITS'(i_dec);
    if (i_inc_en) begin
      w_sum = w_sum + SUM_BITS'(i_inc);
    end
    w_credits_nxt = w_sum[CREDIT_BITS-1:0];
    if (w_sum > SUM_BITS'(CREDIT_MAX)) begin
      w_credits_nxt = CREDIT_BITS'(CREDIT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits <= CREDIT_BITS'(CREDIT_MAX);
    end else begin
      r_credits <= w_credits_nxt;
    end
  end

  assign o_credits = r_credits;

endmodule

// File: rtl/bft_stream_tx.sv
// Credit-based transmitter: packs a 32-bit valid/ready stream into BFT packets for one leaf input port.
module bft_stream_tx
  import bft_pkg::*;
#(
  parameter int unsigned DEST_LEAF = 0,
  parameter int unsigned DEST_PORT = 2,
  parameter int unsigned MY_PORT   = 2
) (
  input logic            clk,
  input logic            ap_rst_n,
  bft_stream_tx_if.slave bus
);

  tx_state_e                r_state;
  tx_state_e                w_state_nxt;
  bft_pkt_t                 r_dout;
  bft_pkt_t                 w_pkt_nxt;
  logic [NUM_ADDR_BITS-1:0] r_wr_addr;
  logic [CREDIT_BITS-1:0]   w_credits;
  logic                     w_tready_c;
  logic                     w_xfer;
  logic                     w_ret_en;
  logic                     w_unused_din;

  assign w_ret_en = bus.din_bft[VALID_BIT] && bus.din_bft[CTRL_BIT]
                 && (bus.din_bft[PORT_MSB:PORT_LSB] == NUM_PORT_BITS'(MY_PORT));
  assign w_unused_din = ^{bus.din_bft[LEAF_MSB:LEAF_LSB], bus.din_bft[ADDR_MSB:ADDR_LSB],
                          bus.din_bft[PAYLOAD_BITS-1:CREDIT_BITS]};

  assign w_tready_c = (r_state == SEND) && (w_credits != '0) && !bus.resend;
  assign w_xfer     = bus.s_tvalid && w_tready_c;

  bft_credit_counter u_credit (
    .clk       (clk),
    .rst_n     (ap_rst_n),
    .i_dec     (w_xfer),
    .i_inc_en  (w_ret_en),
    .i_inc     (bus.din_bft[CREDIT_BITS-1:0]),
    .o_credits (w_credits)
  );

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    w_state_nxt = SEND;
      SEND:    if (w_credits == '0) w_state_nxt = STALL;
      STALL:   if (w_credits != '0) w_state_nxt = SEND;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next outgoing packet: new word, held packet under back-pressure, or an empty slot.
  always_comb begin
    w_pkt_nxt = '0;
    if (w_xfer) begin
      w_pkt_nxt.valid   = 1'b1;
      w_pkt_nxt.leaf    = NUM_LEAF_BITS'(DEST_LEAF);
      w_pkt_nxt.port    = NUM_PORT_BITS'(DEST_PORT);
      w_pkt_nxt.addr    = r_wr_addr;
      w_pkt_nxt.ctrl    = 1'b0;
      w_pkt_nxt.payload = bus.s_tdata;
    end else if (bus.resend) begin
      w_pkt_nxt = r_dout;
    end
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_dout    <= '0;
      r_wr_addr <= '0;
    end else begin
      r_dout <= w_pkt_nxt;
      if (w_xfer) begin
        r_wr_addr <= r_wr_addr + NUM_ADDR_BITS'(1);
      end
    end
  end

  assign bus.s_tready = w_tready_c;
  assign bus.dout_bft = r_dout;
  assign bus.credits  = w_credits;

endmodule

// File: tb/tb_bft_stream_tx.sv
// Self-checking bench for bft_stream_tx: directed table, corner sequences and a randomized run vs. a reference model.
module tb_bft_stream_tx;
  import bft_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bft_stream_tx_if bus ();

  bft_stream_tx #(.DEST_LEAF(0), .DEST_PORT(2), .MY_PORT(2)) dut (
    .clk      (clk),
    .ap_rst_n (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: credit pool, next write address, ready window and expected output packet.
  int          m_credits;
  int          m_addr;
  bit          m_open;
  logic [48:0] m_dout;
  bit          last_xfer;
  logic        obs_rdy;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [48:0] din;
    logic        rs;
    logic        exp_rdy;
    logic [48:0] exp_dout;
    logic [7:0]  exp_cred;
  } vec_t;
  vec_t tbl[9];

  function automatic logic [48:0] pkt(input int a, input logic [31:0] d);
    return {1'b1, 4'd0, 4'd2, 7'(a), 1'b0, d};
  endfunction

  function automatic logic [48:0] cpkt(input int port, input bit ctrl, input int amt);
    return {1'b1, 4'd0, 4'(port), 7'd0, ctrl, 32'(amt)};
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic [48:0] din, input logic rs,
                              input logic er, input logic [48:0] ed, input logic [7:0] ec);
    vec_t t;
    t.v = v; t.d = d; t.din = din; t.rs = rs; t.exp_rdy = er; t.exp_dout = ed; t.exp_cred = ec;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credits = 128;
    m_addr    = 0;
    m_open    = 1'b0;
    m_dout    = '0;
  endtask

  // One clock: drive at negedge, check ready, advance model at posedge, check registered outputs at next negedge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic [48:0] din, input logic rs);
    bit exp_rdy;
    int ret;
    bus.s_tvalid = v;
    bus.s_tdata  = d;
    bus.din_bft  = din;
    bus.resend   = rs;
    #1;
    exp_rdy = m_open && (m_credits != 0) && !rs;
    obs_rdy = bus.s_tready;
    chk("s_tready", 64'(bus.s_tready), 64'(exp_rdy));
    last_xfer = v && exp_rdy;
    ret = (din[48] && din[32] && din[43:40] == 4'd2) ? int'(din[7:0]) : 0;
    @(posedge clk);
    m_open = (m_credits != 0);
    m_dout = last_xfer ? pkt(m_addr, d) : (rs ? m_dout : 49'd0);
    if (last_xfer) m_addr = (m_addr + 1) % 128;
    m_credits = m_credits - (last_xfer ? 1 : 0) + ret;
    if (m_credits > 128) m_credits = 128;
    @(negedge clk);
    chk("dout_bft", 64'(bus.dout_bft), 64'(m_dout));
    chk("credits", 64'(bus.credits), 64'(m_credits));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n        = 1'b0;
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    bus.din_bft  = '0;
    bus.resend   = 1'b0;
    #1;
    chk("rst dout_bft", 64'(bus.dout_bft), 64'd0);
    chk("rst credits", 64'(bus.credits), 64'd128);
    chk("rst s_tready", 64'(bus.s_tready), 64'd0);
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // Stream consecutive words until 'count' are accepted (bounded).
  task automatic send_words(input int first, input int count, input int budget);
    int acc = 0;
    for (int n = 0; n < budget && acc < count; n++) begin
      cycle(1'b1, 32'(first + acc), '0, 1'b0);
      if (last_xfer) acc++;
    end
    chk("burst accepted", 64'(acc), 64'(count));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    bus.din_bft  = '0;
    bus.resend   = 1'b0;
    model_reset();

    tbl[0] = mk(1'b1, 32'hAAAA, '0,              1'b0, 1'b0, '0,           8'd128);
    tbl[1] = mk(1'b1, 32'h11,   '0,              1'b0, 1'b1, pkt(0, 'h11), 8'd127);
    tbl[2] = mk(1'b0, 32'h0,    '0,              1'b0, 1'b1, '0,           8'd127);
    tbl[3] = mk(1'b1, 32'h22,   cpkt(3, 1, 5),   1'b0, 1'b1, pkt(1, 'h22), 8'd126);
    tbl[4] = mk(1'b0, 32'h0,    cpkt(2, 0, 5),   1'b0, 1'b1, '0,           8'd126);
    tbl[5] = mk(1'b1, 32'h33,   cpkt(2, 1, 0),   1'b0, 1'b1, pkt(2, 'h33), 8'd125);
    tbl[6] = mk(1'b1, 32'h44,   '0,              1'b1, 1'b0, pkt(2, 'h33), 8'd125);
    tbl[7] = mk(1'b1, 32'h44,   cpkt(2, 1, 2),   1'b0, 1'b1, pkt(3, 'h44), 8'd126);
    tbl[8] = mk(1'b0, 32'h0,    cpkt(2, 1, 10),  1'b0, 1'b1, '0,           8'd128);

    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].din, tbl[i].rs);
      chk($sformatf("tbl[%0d] rdy", i), 64'(obs_rdy), 64'(tbl[i].exp_rdy));
      chk($sformatf("tbl[%0d] dout", i), 64'(bus.dout_bft), 64'(tbl[i].exp_dout));
      chk($sformatf("tbl[%0d] credits", i), 64'(bus.credits), 64'(tbl[i].exp_cred));
    end

    // Full burst drains every credit, then the transmitter must stall.
    do_reset();
    send_words(0, 128, 400);
    chk("drained credits", 64'(bus.credits), 64'd0);
    chk("last packet", 64'(bus.dout_bft), 64'(pkt(127, 127)));
    cycle(1'b1, 32'd999, '0, 1'b0);
    chk("stall ready", 64'(obs_rdy), 64'd0);
    cycle(1'b1, 32'd999, '0, 1'b0);
    chk("stall idle dout", 64'(bus.dout_bft), 64'd0);

    cycle(1'b0, '0, cpkt(2, 1, 64), 1'b0);
    chk("refill 64", 64'(bus.credits), 64'd64);
    send_words(1000, 64, 200);
    chk("wrapped addr 63", 64'(bus.dout_bft), 64'(pkt(63, 1063)));
    chk("drained again", 64'(bus.credits), 64'd0);
    cycle(1'b0, '0, cpkt(3, 1, 20), 1'b0);
    cycle(1'b0, '0, cpkt(2, 0, 20), 1'b0);
    chk("ignored returns", 64'(bus.credits), 64'd0);

    // Back-pressure holds packet 5 for three cycles with no loss or duplication.
    do_reset();
    send_words(0, 6, 40);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 32'd6, '0, 1'b1);
      chk("resend ready", 64'(obs_rdy), 64'd0);
      chk("resend hold", 64'(bus.dout_bft), 64'(pkt(5, 5)));
    end
    send_words(6, 4, 20);
    chk("after resend", 64'(bus.dout_bft), 64'(pkt(9, 9)));

    // Simultaneous send and return at credits==1, then saturation at 128.
    do_reset();
    send_words(0, 127, 300);
    chk("one credit", 64'(bus.credits), 64'd1);
    cycle(1'b1, 32'hBEEF, cpkt(2, 1, 64), 1'b0);
    chk("send+return", 64'(bus.credits), 64'd64);
    chk("send+return pkt", 64'(bus.dout_bft), 64'(pkt(127, 'hBEEF)));
    cycle(1'b0, '0, cpkt(2, 1, 64), 1'b0);
    cycle(1'b0, '0, cpkt(2, 1, 64), 1'b0);
    chk("saturate", 64'(bus.credits), 64'd128);

    // Reset in the middle of a burst restarts addressing at 0.
    send_words(500, 5, 20);
    do_reset();
    cycle(1'b1, 32'h77, '0, 1'b0);
    cycle(1'b1, 32'h77, '0, 1'b0);
    chk("post-reset addr0", 64'(bus.dout_bft), 64'(pkt(0, 'h77)));

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [48:0] din;
      int sel;
      sel = int'($urandom_range(0, 7));
      if (sel < 2)       din = {17'($urandom), 32'($urandom)};
      else if (sel == 2) din = cpkt(int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 7)));
      else if (sel == 3) din = cpkt(2, 1, int'($urandom_range(0, 7)));
      else               din = '0;
      cycle(($urandom % 4) != 0, $urandom, din, ($urandom % 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
